// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared types for the HI/LO sequencer: HI/LO op codes, FSM states and
// op-class helpers used by the issue decode.
package muldiv_hilo_ctrl_pkg;

    typedef enum logic [3:0] {
        MULT  = 4'd0,
        MULTU = 4'd1,
        DIV   = 4'd2,
        DIVU  = 4'd3,
        MADD  = 4'd4,
        MADDU = 4'd5,
        MSUB  = 4'd6,
        MSUBU = 4'd7,
        MTHI  = 4'd8,
        MTLO  = 4'd9
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_REQ  = 3'd1,
        S_MUL_WAIT = 3'd2,
        S_DIV_REQ  = 3'd3,
        S_DIV_WAIT = 3'd4
    } state_e;

    function automatic logic is_mul_op(input op_e op);
        return op inside {MULT, MULTU, MADD, MADDU, MSUB, MSUBU};
    endfunction

    function automatic logic is_div_op(input op_e op);
        return op inside {DIV, DIVU};
    endfunction

    function automatic logic is_acc_op(input op_e op);
        return op inside {MADD, MADDU, MSUB, MSUBU};
    endfunction

    function automatic logic is_signed_op(input op_e op);
        return op inside {MULT, DIV, MADD, MSUB};
    endfunction

    function automatic logic is_add_op(input op_e op);
        return op inside {MADD, MADDU};
    endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_hilo_regfile.sv
// Architectural HI/LO storage with independent write enables and a read
// port that forwards a same-cycle write.
module hilo_regfile
    import muldiv_hilo_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hi_we_i,
    input  logic [W-1:0] hi_wdata_i,
    input  logic         lo_we_i,
    input  logic [W-1:0] lo_wdata_i,
    input  logic         rd_sel_i,
    output logic [W-1:0] rd_data_o,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);

    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_we_i ? hi_wdata_i : hi_q;
        lo_d = lo_we_i ? lo_wdata_i : lo_q;
    end

    // NOTE: reset is sampled on the clock edge only (synchronous, active-low);
    // state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Reading the next-state value forwards any write landing this edge.
    assign rd_data_o = rd_sel_i ? hi_d : lo_d;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// EXE-stage sequencer for HI/LO-writing ops: one op in flight on the shared
// multiplier or divider, MFHI/MFLO stall and forwarding, flush cancel.
module muldiv_hilo_ctrl
    import muldiv_hilo_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           issue_valid,
    input  op_e            issue_op,
    input  logic [W-1:0]   issue_a,
    input  logic [W-1:0]   issue_b,
    output logic           issue_ready,
    input  logic           flush,
    input  logic           mf_req,
    input  logic           mf_sel,
    output logic [W-1:0]   mf_data,
    output logic           mf_stall,
    output logic           busy,
    output logic           mul_req,
    output logic           mul_signed,
    output logic           mul_acc,
    output logic           mul_addsub,
    output logic [2*W-1:0] mul_opnd,
    output logic [2*W-1:0] mul_hilo,
    input  logic           mul_opnd_ok,
    input  logic           mul_data_ok,
    input  logic [2*W-1:0] mul_res,
    output logic           mul_cancel,
    output logic           div_req,
    output logic           div_signed,
    output logic [2*W-1:0] div_opnd,
    input  logic           div_opnd_ok,
    input  logic           div_data_ok,
    input  logic [2*W-1:0] div_res,
    output logic           div_cancel
);

    state_e         state_q;
    logic [W-1:0]   a_q, b_q;
    logic [2*W-1:0] snap_q;
    logic           mul_req_q, mul_signed_q, mul_acc_q, mul_addsub_q, mul_cancel_q;
    logic           div_req_q, div_signed_q, div_cancel_q;

    logic           accept, mt_hi, mt_lo, mul_retire, div_retire, retire;
    logic [2*W-1:0] res;
    logic           hi_we, lo_we;
    logic [W-1:0]   hi_wdata, lo_wdata, hi, lo;

    assign issue_ready = (state_q == S_IDLE) && !flush;
    assign accept      = issue_valid && issue_ready;
    assign mt_hi       = accept && (issue_op == MTHI);
    assign mt_lo       = accept && (issue_op == MTLO);

    // A flush in the same cycle as data_ok drops the result.
    assign mul_retire = (state_q == S_MUL_WAIT) && mul_data_ok && !flush;
    assign div_retire = (state_q == S_DIV_WAIT) && div_data_ok && !flush;
    assign retire     = mul_retire || div_retire;
    assign res        = mul_retire ? mul_res : div_res;

    // Retire and MT accept are exclusive: accept happens only in IDLE.
    assign hi_we    = retire || mt_hi;
    assign lo_we    = retire || mt_lo;
    assign hi_wdata = retire ? res[2*W-1:W] : issue_a;
    assign lo_wdata = retire ? res[W-1:0]   : issue_a;

    hilo_regfile #(.W(W)) u_hilo (
        .clk        (clk),
        .rst        (rst),
        .hi_we_i    (hi_we),
        .hi_wdata_i (hi_wdata),
        .lo_we_i    (lo_we),
        .lo_wdata_i (lo_wdata),
        .rd_sel_i   (mf_sel),
        .rd_data_o  (mf_data),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            snap_q       <= '0;
            mul_req_q    <= 1'b0;
            mul_signed_q <= 1'b0;
            mul_acc_q    <= 1'b0;
            mul_addsub_q <= 1'b0;
            mul_cancel_q <= 1'b0;
            div_req_q    <= 1'b0;
            div_signed_q <= 1'b0;
            div_cancel_q <= 1'b0;
        end else begin
            mul_cancel_q <= 1'b0;
            div_cancel_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        a_q    <= issue_a;
                        b_q    <= issue_b;
                        snap_q <= {hi, lo};
                        if (is_mul_op(issue_op)) begin
                            state_q      <= S_MUL_REQ;
                            mul_req_q    <= 1'b1;
                            mul_signed_q <= is_signed_op(issue_op);
                            mul_acc_q    <= is_acc_op(issue_op);
                            mul_addsub_q <= is_add_op(issue_op);
                        end else if (is_div_op(issue_op)) begin
                            state_q      <= S_DIV_REQ;
                            div_req_q    <= 1'b1;
                            div_signed_q <= is_signed_op(issue_op);
                        end
                    end
                end
                S_MUL_REQ, S_MUL_WAIT: begin
                    if (flush) begin
                        state_q      <= S_IDLE;
                        mul_req_q    <= 1'b0;
                        mul_cancel_q <= 1'b1;
                    end else if (state_q == S_MUL_REQ && mul_opnd_ok) begin
                        state_q   <= S_MUL_WAIT;
                        mul_req_q <= 1'b0;
                    end else if (state_q == S_MUL_WAIT && mul_data_ok) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DIV_REQ, S_DIV_WAIT: begin
                    if (flush) begin
                        state_q      <= S_IDLE;
                        div_req_q    <= 1'b0;
                        div_cancel_q <= 1'b1;
                    end else if (state_q == S_DIV_REQ && div_opnd_ok) begin
                        state_q   <= S_DIV_WAIT;
                        div_req_q <= 1'b0;
                    end else if (state_q == S_DIV_WAIT && div_data_ok) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign mf_stall   = mf_req && busy && !retire;
    assign mul_req    = mul_req_q;
    assign mul_signed = mul_signed_q;
    assign mul_acc    = mul_acc_q;
    assign mul_addsub = mul_addsub_q;
    assign mul_opnd   = {b_q, a_q};
    assign mul_hilo   = snap_q;
    assign mul_cancel = mul_cancel_q;
    assign div_req    = div_req_q;
    assign div_signed = div_signed_q;
    assign div_opnd   = {b_q, a_q};
    assign div_cancel = div_cancel_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed plus randomized bench for muldiv_hilo_ctrl; the bench plays the
// multiplier/divider and keeps an arithmetic HI/LO reference model.
module tb_muldiv_hilo_ctrl;
    import muldiv_hilo_ctrl_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    logic issue_valid;
    op_e issue_op;
    logic [W-1:0] issue_a, issue_b;
    logic issue_ready;
    logic flush, mf_req, mf_sel;
    logic [W-1:0] mf_data;
    logic mf_stall, busy;
    logic mul_req, mul_signed, mul_acc, mul_addsub, mul_cancel;
    logic [2*W-1:0] mul_opnd, mul_hilo, mul_res;
    logic mul_opnd_ok, mul_data_ok;
    logic div_req, div_signed, div_cancel;
    logic [2*W-1:0] div_opnd, div_res;
    logic div_opnd_ok, div_data_ok;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] hi_m = '0;
    logic [W-1:0] lo_m = '0;

    always #5 clk = ~clk;

    muldiv_hilo_ctrl #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_a(issue_a), .issue_b(issue_b),
        .issue_ready(issue_ready), .flush(flush),
        .mf_req(mf_req), .mf_sel(mf_sel), .mf_data(mf_data), .mf_stall(mf_stall), .busy(busy),
        .mul_req(mul_req), .mul_signed(mul_signed), .mul_acc(mul_acc), .mul_addsub(mul_addsub),
        .mul_opnd(mul_opnd), .mul_hilo(mul_hilo), .mul_opnd_ok(mul_opnd_ok),
        .mul_data_ok(mul_data_ok), .mul_res(mul_res), .mul_cancel(mul_cancel),
        .div_req(div_req), .div_signed(div_signed), .div_opnd(div_opnd),
        .div_opnd_ok(div_opnd_ok), .div_data_ok(div_data_ok), .div_res(div_res),
        .div_cancel(div_cancel)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic for what the multiplier/divider return.
    function automatic logic [63:0] model_result(input op_e op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [63:0] hilo);
        longint la, lb, sp;
        logic [63:0] up;
        int sa, sb, q, r;
        sa = int'(a);
        sb = int'(b);
        la = sa;
        lb = sb;
        sp = la * lb;
        up = {32'b0, a} * {32'b0, b};
        case (op)
            MULT:  return sp;
            MULTU: return up;
            MADD:  return hilo + sp;
            MADDU: return hilo + up;
            MSUB:  return hilo - sp;
            MSUBU: return hilo - up;
            DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
            DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return hilo;
        endcase
    endfunction

    task automatic read_check(input string tag);
        @(negedge clk);
        mf_req = 1'b1;
        mf_sel = 1'b1;
        #1 check({tag, "_hi"}, mf_data, hi_m);
        check({tag, "_stall"}, mf_stall, 1'b0);
        mf_sel = 1'b0;
        #1 check({tag, "_lo"}, mf_data, lo_m);
        mf_req = 1'b0;
    endtask

    task automatic do_mt(input op_e op, input logic [W-1:0] a, input logic fl);
        @(negedge clk);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_a     = a;
        issue_b     = $urandom;
        flush       = fl;
        mf_req      = 1'b1;
        mf_sel      = (op == MTHI);
        #1 check("mt_ready", issue_ready, !fl);
        if (!fl) check("mt_bypass", mf_data, a);
        @(posedge clk);
        if (!fl) begin
            if (op == MTHI) hi_m = a;
            else lo_m = a;
        end
        @(negedge clk);
        issue_valid = 1'b0;
        flush       = 1'b0;
        mf_req      = 1'b0;
        #1 check("mt_busy", busy, 1'b0);
        check("mt_mul_cancel", mul_cancel, 1'b0);
        check("mt_div_cancel", div_cancel, 1'b0);
        read_check("mt");
    endtask

    // abort: 0 none, 1 flush at cycle abort_at, 2 reset at cycle abort_at.
    task automatic run_unit(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int req_lat, input int res_lat, input int abort,
                            input int abort_at, input logic mf_on, input logic mf_sel_v);
        bit is_mul, exp_acc, exp_sgn, exp_add, aborted;
        int k_last;
        logic [63:0] exp_res;
        is_mul  = !(op inside {DIV, DIVU});
        exp_acc = op inside {MADD, MADDU, MSUB, MSUBU};
        exp_sgn = op inside {MULT, MADD, MSUB, DIV};
        exp_add = op inside {MADD, MADDU};
        k_last  = 1 + req_lat + res_lat;
        exp_res = model_result(op, a, b, {hi_m, lo_m});
        aborted = 1'b0;

        @(negedge clk);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_a     = a;
        issue_b     = b;
        #1 check("issue_ready_idle", issue_ready, 1'b1);
        @(posedge clk);
        for (int k = 1; k <= k_last; k++) begin
            bit hs, last, ab, in_req;
            @(negedge clk);
            hs     = (k == 1 + req_lat);
            last   = (k == k_last);
            ab     = (abort != 0) && (k == abort_at);
            in_req = (k <= 1 + req_lat);
            issue_valid = 1'b0;
            mul_opnd_ok = is_mul && hs;
            div_opnd_ok = !is_mul && hs;
            mul_data_ok = is_mul && last;
            div_data_ok = !is_mul && last;
            mul_res     = last ? exp_res : {$urandom, $urandom};
            div_res     = last ? exp_res : {$urandom, $urandom};
            flush       = (abort == 1) && ab;
            rst         = !((abort == 2) && ab);
            mf_req      = mf_on;
            mf_sel      = mf_sel_v;
            #1;
            check("busy", busy, 1'b1);
            check("issue_ready_busy", issue_ready, 1'b0);
            check("mul_req", mul_req, is_mul && in_req);
            check("div_req", div_req, !is_mul && in_req);
            check("mul_cancel_active", mul_cancel, 1'b0);
            check("div_cancel_active", div_cancel, 1'b0);
            if (in_req && is_mul) begin
                check("mul_opnd", mul_opnd, {b, a});
                check("mul_acc", mul_acc, exp_acc);
                check("mul_signed", mul_signed, exp_sgn);
                if (exp_acc) begin
                    check("mul_addsub", mul_addsub, exp_add);
                    check("mul_hilo", mul_hilo, {hi_m, lo_m});
                end
            end
            if (in_req && !is_mul) begin
                check("div_opnd", div_opnd, {b, a});
                check("div_signed", div_signed, exp_sgn);
            end
            if (mf_on) begin
                check("mf_stall", mf_stall, !(last && !flush));
                if (last && !flush)
                    check("mf_bypass", mf_data, mf_sel_v ? exp_res[63:32] : exp_res[31:0]);
            end
            @(posedge clk);
            if (ab) begin
                aborted = 1'b1;
                break;
            end
        end

        @(negedge clk);
        mul_opnd_ok = 1'b0;
        div_opnd_ok = 1'b0;
        mul_data_ok = 1'b0;
        div_data_ok = 1'b0;
        flush       = 1'b0;
        rst         = 1'b1;
        mf_req      = 1'b0;
        if (!aborted) {hi_m, lo_m} = exp_res;
        else if (abort == 2) {hi_m, lo_m} = '0;
        #1 check("busy_after", busy, 1'b0);
        check("mul_req_after", mul_req, 1'b0);
        check("div_req_after", div_req, 1'b0);
        check("mul_cancel_pulse", mul_cancel, aborted && abort == 1 && is_mul);
        check("div_cancel_pulse", div_cancel, aborted && abort == 1 && !is_mul);
        if (aborted && abort == 1) begin
            @(negedge clk);
            #1 check("mul_cancel_single", mul_cancel, 1'b0);
            check("div_cancel_single", div_cancel, 1'b0);
        end
        read_check("after_op");
    endtask

    initial begin
        rst = 1'b0;
        issue_valid = 1'b0;
        issue_op = MULT;
        issue_a = '0;
        issue_b = '0;
        flush = 1'b0;
        mf_req = 1'b0;
        mf_sel = 1'b0;
        mul_opnd_ok = 1'b0;
        mul_data_ok = 1'b0;
        mul_res = '0;
        div_opnd_ok = 1'b0;
        div_data_ok = 1'b0;
        div_res = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        mf_req = 1'b1;
        mf_sel = 1'b1;
        #1 check("rst_busy", busy, 1'b0);
        check("rst_mul_req", mul_req, 1'b0);
        check("rst_div_req", div_req, 1'b0);
        check("rst_mul_cancel", mul_cancel, 1'b0);
        check("rst_div_cancel", div_cancel, 1'b0);
        check("rst_mf_stall", mf_stall, 1'b0);
        check("rst_hi", mf_data, '0);
        mf_sel = 1'b0;
        #1 check("rst_lo", mf_data, '0);
        check("rst_ready", issue_ready, 1'b1);
        mf_req = 1'b0;
        rst = 1'b1;

        // MULT -2*3, multiplier latency 2: busy exactly three cycles
        run_unit(MULT, 32'hFFFF_FFFE, 32'd3, 0, 2, 0, 0, 1'b0, 1'b0);

        // MTHI 0, MTLO 5, then MADDU 2*3 accumulating onto {0,5}
        do_mt(MTHI, 32'd0, 1'b0);
        do_mt(MTLO, 32'd5, 1'b0);
        run_unit(MADDU, 32'd2, 32'd3, 1, 4, 0, 0, 1'b0, 1'b0);

        // Signed DIV 7 / -2
        run_unit(DIV, 32'd7, 32'hFFFF_FFFE, 0, 3, 0, 0, 1'b0, 1'b0);

        // MFHI waiting on an in-flight MULT, forwarded in the retire cycle
        run_unit(MULT, $urandom, $urandom, 1, 2, 0, 0, 1'b1, 1'b1);

        // Flush in MUL_WAIT, then flush coincident with div_data_ok
        run_unit(MULTU, $urandom, $urandom, 0, 3, 1, 3, 1'b1, 1'b0);
        run_unit(DIVU, $urandom, 32'd9, 1, 2, 1, 4, 1'b1, 1'b1);

        // Flush in IDLE blocks an MTHI accept
        do_mt(MTHI, 32'hDEAD_BEEF, 1'b1);

        // Divide by zero writes whatever the divider returns
        run_unit(DIV, 32'd123, 32'd0, 0, 1, 0, 0, 1'b1, 1'b0);

        // Reset while in DIV_WAIT
        run_unit(DIV, 32'd100, 32'd7, 0, 3, 2, 2, 1'b0, 1'b0);

        // Randomized mix
        repeat (40) begin
            op_e op;
            logic [W-1:0] a, b;
            int rl, sl, kl, ab;
            op = op_e'($urandom_range(9));
            a  = $urandom;
            b  = $urandom;
            if (op == MTHI || op == MTLO) begin
                do_mt(op, a, $urandom_range(7) == 0);
            end else begin
                if (b == 0 || (op == DIV && b == 32'hFFFF_FFFF)) b = 32'd3;
                rl = $urandom_range(2);
                sl = $urandom_range(3, 1);
                kl = 1 + rl + sl;
                ab = ($urandom_range(5) == 0) ? 1 : 0;
                run_unit(op, a, b, rl, sl, ab, $urandom_range(kl, 1),
                         1'($urandom_range(1)), 1'($urandom_range(1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
